// File: rtl/text_pkg.sv
// Shared definitions for the text panel: the clear FSM state encoding, the
// special character codes and the 8x8 glyph ROM contents.
// Glyph rows are packed MSB first: byte 0 (top row) sits in bits [63:56],
// and bit 7 of each byte is the leftmost pixel of that row.
package text_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [5:0] CHAR_DASH  = 6'd37;
  localparam logic [5:0] CHAR_HEART = 6'd38;
  localparam logic [5:0] CHAR_BLANK = 6'd39;

  // Codes 0-9 are digits, 10-35 are 'a'-'z', 36 is an alternate 'h'
  // (block style), then dash, heart and blank. Codes 40..63 draw nothing.
  function automatic logic [63:0] glyph_bits(input logic [5:0] code);
    logic [63:0] g;
    case (code)
      6'd0:  g = 64'h3C666E7666663C00;
      6'd1:  g = 64'h1838181818187E00;
      6'd2:  g = 64'h3C66060C30607E00;
      6'd3:  g = 64'h3C66061C06663C00;
      6'd4:  g = 64'h0C1C3C6C7E0C0C00;
      6'd5:  g = 64'h7E607C0606663C00;
      6'd6:  g = 64'h3C607C6666663C00;
      6'd7:  g = 64'h7E060C1830303000;
      6'd8:  g = 64'h3C66663C66663C00;
      6'd9:  g = 64'h3C66663E060C3800;
      6'd10: g = 64'h00003C063E663E00;
      6'd11: g = 64'h60607C6666667C00;
      6'd12: g = 64'h00003C6060603C00;
      6'd13: g = 64'h06063E6666663E00;
      6'd14: g = 64'h00003C667E603C00;
      6'd15: g = 64'h1C307C3030303000;
      6'd16: g = 64'h00003E66663E063C;
      6'd17: g = 64'h60607C6666666600;
      6'd18: g = 64'h1800381818183C00;
      6'd19: g = 64'h0C001C0C0C0C6C38;
      6'd20: g = 64'h6060666C786C6600;
      6'd21: g = 64'h3818181818183C00;
      6'd22: g = 64'h0000667F7F6B6300;
      6'd23: g = 64'h00007C6666666600;
      6'd24: g = 64'h00003C6666663C00;
      6'd25: g = 64'h00007C66667C6060;
      6'd26: g = 64'h00003E66663E0606;
      6'd27: g = 64'h00007C6660606000;
      6'd28: g = 64'h00003E603C067C00;
      6'd29: g = 64'h30307C3030301C00;
      6'd30: g = 64'h0000666666663E00;
      6'd31: g = 64'h00006666663C1800;
      6'd32: g = 64'h0000636B7F3E3600;
      6'd33: g = 64'h0000663C183C6600;
      6'd34: g = 64'h00006666663E0C78;
      6'd35: g = 64'h00007E0C18307E00;
      6'd36: g = 64'h6666667E66666600;
      6'd37: g = 64'h0000007E00000000;
      6'd38: g = 64'h0066FFFF7E3C1800;
      default: g = 64'h0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/text_glyph_rom.sv
// 40-entry x 64-bit glyph ROM with a registered read (1-cycle latency).
// Ports: clk - clock; i_code - character code; o_glyph - 8x8 bitmap of the
// code presented on the previous cycle.
module text_glyph_rom
  import text_pkg::*;
(
  input  logic        clk,
  input  logic [5:0]  i_code,
  output logic [63:0] o_glyph
);

  logic [63:0] r_glyph;

  always_ff @(posedge clk) begin
    r_glyph <= glyph_bits(i_code);
  end

  assign o_glyph = r_glyph;

endmodule

// File: rtl/text_panel.sv
// Character-cell text overlay for an LCD pixel stream.
// Holds COLS*ROWS 6-bit character codes, blanks them after reset or on a
// clear pulse, and renders each pixel coordinate to a colour two cycles later.
// Ports: clk/rst_n - clock and async active-low reset; lcd_xpos/lcd_ypos -
// pixel coordinates; enable - display gate; frame_start - frame pulse (blink
// timing); wr_valid/wr_ready/wr_addr/wr_char - character write handshake;
// clear/busy - buffer blank request and progress; word_pixel/pixel_valid -
// rendered colour and glyph-hit flag.
// Build option: define TEXT_BLINK_EN to add the wr_blink input, per-character
// blink storage and a blink phase that toggles every 32 frames.
module text_panel
  import text_pkg::*;
#(
  parameter int          TEXT_X0  = 0,
  parameter int          TEXT_Y0  = 0,
  parameter int          SCALE    = 3,
  parameter int          COLS     = 18,
  parameter int          ROWS     = 2,
  parameter int          ORIENT   = 1,
  parameter logic [23:0] FG_COLOR = 24'hffffff,
  parameter logic [23:0] BG_COLOR = 24'h030307
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [11:0]                   lcd_xpos,
  input  logic [11:0]                   lcd_ypos,
  input  logic                          enable,
  input  logic                          frame_start,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(COLS*ROWS)-1:0]  wr_addr,
  input  logic [5:0]                    wr_char,
`ifdef TEXT_BLINK_EN
  input  logic                          wr_blink,
`endif
  input  logic                          clear,
  output logic                          busy,
  output logic [23:0]                   word_pixel,
  output logic                          pixel_valid
);

  localparam int NCHARS = COLS * ROWS;
  localparam int AW     = $clog2(NCHARS);
  localparam logic signed [12:0] X0S = 13'(TEXT_X0);
  localparam logic signed [12:0] Y0S = 13'(TEXT_Y0);
  localparam logic [12:0] CELL13 = 13'(8 * SCALE);
  localparam logic [12:0] SC13   = 13'(SCALE);
  localparam logic [12:0] EXT_L  = 13'(8 * SCALE * COLS);  // along a line
  localparam logic [12:0] EXT_A  = 13'(8 * SCALE * ROWS);  // across lines

  // ---------------- clear FSM and write port ----------------
  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_clr_addr;
  logic            w_wr_hit, w_we;
  logic [AW-1:0]   w_waddr;
  logic [5:0]      w_wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (clear) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_clr_addr == AW'(NCHARS - 1)) w_state_next = ST_IDLE;
      default:  w_state_next = ST_CLEAR;
    endcase
  end

  // Reset lands in CLEAR so the buffer is always blanked after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR && w_state_next == ST_CLEAR)
        r_clr_addr <= r_clr_addr + 1'b1;
      else
        r_clr_addr <= '0;
    end
  end

  assign busy     = (r_state == ST_CLEAR);
  assign wr_ready = (r_state == ST_IDLE) && !clear;
  // Out-of-range addresses complete the handshake but store nothing.
  assign w_wr_hit = wr_valid && wr_ready && (32'(wr_addr) < 32'(NCHARS));
  assign w_we     = busy || w_wr_hit;
  assign w_waddr  = busy ? r_clr_addr : wr_addr;
  assign w_wdata  = busy ? CHAR_BLANK : wr_char;

  // ---------------- stage 0: coordinate decode ----------------
  logic signed [12:0] w_dx, w_dy;
  logic [12:0]        w_ux, w_uy, w_qx, w_qy, w_col, w_row, w_addr13;
  logic               w_inside0;
  logic [2:0]         w_byte0, w_bit0;
  logic [AW-1:0]      w_rd_addr;

  assign w_dx = $signed({1'b0, lcd_xpos}) - X0S;
  assign w_dy = $signed({1'b0, lcd_ypos}) - Y0S;
  assign w_ux = w_dx;
  assign w_uy = w_dy;
  assign w_qx = w_ux / SC13;
  assign w_qy = w_uy / SC13;

  generate
    if (ORIENT == 0) begin : g_horiz
      assign w_inside0 = enable && !w_dx[12] && !w_dy[12] &&
                         (w_ux < EXT_L) && (w_uy < EXT_A);
      assign w_col   = w_ux / CELL13;
      assign w_row   = w_uy / CELL13;
      assign w_byte0 = w_qy[2:0];
      assign w_bit0  = 3'd7 - w_qx[2:0];
    end else begin : g_rot
      // Rotated panel: lines run down Y with the first character at the
      // far end, and glyph rows run along X.
      assign w_inside0 = enable && !w_dx[12] && !w_dy[12] &&
                         (w_uy < EXT_L) && (w_ux < EXT_A);
      assign w_col   = 13'(COLS - 1) - (w_uy / CELL13);
      assign w_row   = w_ux / CELL13;
      assign w_byte0 = w_qx[2:0];
      assign w_bit0  = w_qy[2:0];
    end
  endgenerate

  assign w_addr13  = w_row * 13'(COLS) + w_col;
  assign w_rd_addr = w_inside0 ? w_addr13[AW-1:0] : '0;

  // ---------------- character buffer (registered read) ----------------
  // A same-cycle read of the address being written returns the old code.
  logic [5:0] r_buf [NCHARS];
  logic [5:0] r_char1;

  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_wdata;
    r_char1 <= r_buf[w_rd_addr];
  end

  logic w_hide1;
  logic w_unused_bits;

`ifdef TEXT_BLINK_EN
  logic       r_blink_buf [NCHARS];
  logic       r_blink1;
  logic       r_phase;
  logic [4:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (w_we) r_blink_buf[w_waddr] <= busy ? 1'b0 : wr_blink;
    r_blink1 <= r_blink_buf[w_rd_addr];
  end

  // Phase flips on every 32nd frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (frame_start) begin
      r_frame_cnt <= r_frame_cnt + 5'd1;
      if (r_frame_cnt == 5'd31) r_phase <= ~r_phase;
    end
  end

  assign w_hide1       = r_blink1 && r_phase;
  assign w_unused_bits = ^{w_qx[12:3], w_qy[12:3], w_addr13[12:AW]};
`else
  assign w_hide1       = 1'b0;
  assign w_unused_bits = ^{w_qx[12:3], w_qy[12:3], w_addr13[12:AW], frame_start};
`endif

  // ---------------- pipeline sidebands ----------------
  logic       r_inside1, r_inside2, r_hide2;
  logic [2:0] r_byte1, r_bit1, r_byte2, r_bit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inside1 <= 1'b0;
      r_inside2 <= 1'b0;
      r_hide2   <= 1'b0;
      r_byte1   <= '0;
      r_bit1    <= '0;
      r_byte2   <= '0;
      r_bit2    <= '0;
    end else begin
      r_inside1 <= w_inside0;
      r_byte1   <= w_byte0;
      r_bit1    <= w_bit0;
      r_inside2 <= r_inside1;
      r_byte2   <= r_byte1;
      r_bit2    <= r_bit1;
      r_hide2   <= w_hide1;
    end
  end

  // ---------------- stage 2: glyph lookup and colour ----------------
  logic [63:0] w_glyph;
  logic        w_on;

  text_glyph_rom u_rom (
    .clk     (clk),
    .i_code  (r_char1),
    .o_glyph (w_glyph)
  );

  // Byte b, bit k lives at bit 8*(7-b)+k, i.e. index {~b, k}.
  assign w_on        = r_inside2 && !r_hide2 && w_glyph[{~r_byte2, r_bit2}];
  assign pixel_valid = w_on;
  assign word_pixel  = w_on ? FG_COLOR : BG_COLOR;

endmodule

// File: doc/text_panel.md
TEXT_PANEL -- requirements
Module: text_panel

Interface
REQ-001 SHALL have parameter TEXT_X0, default 0, panel origin X in pixels.
REQ-002 SHALL have parameter TEXT_Y0, default 0, panel origin Y in pixels.
REQ-003 SHALL have parameter SCALE, default 3, integer glyph magnification (1..8).
REQ-004 SHALL have parameter COLS, default 18, characters per line.
REQ-005 SHALL have parameter ROWS, default 2, number of text lines.
REQ-006 SHALL have parameter ORIENT, default 1, 0 = lines run along X, 1 = lines run along Y with reversed character order (rotated panel).
REQ-007 SHALL have parameter FG_COLOR, default 24'hffffff, glyph colour.
REQ-008 SHALL have parameter BG_COLOR, default 24'h030307, background colour.
REQ-009 SHALL have port clk, input, 1, sole clock.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have ports lcd_xpos and lcd_ypos, input, 12 each, current pixel coordinates.
REQ-012 SHALL have port enable, input, 1, display gate.
REQ-013 SHALL have port frame_start, input, 1, one-cycle pulse per frame.
REQ-014 SHALL have ports wr_valid (in, 1), wr_ready (out, 1), wr_addr (in, clog2(COLS*ROWS)), wr_char (in, 6): character write handshake.
REQ-015 SHALL have ports clear (in, 1, pulse) and busy (out, 1, clear in progress).
REQ-016 SHALL have ports word_pixel (out, 24) and pixel_valid (out, 1).

Function
REQ-017 SHALL store COLS*ROWS 6-bit codes in an internal buffer, address = row*COLS + col.
REQ-018 SHALL accept a write when wr_valid && wr_ready; wr_ready = (state == IDLE) && !clear; addresses >= COLS*ROWS are accepted and discarded.
REQ-019 SHALL implement FSM IDLE/CLEAR: clear in IDLE -> CLEAR; CLEAR writes code 39 (blank) to one address per cycle starting at 0, returning to IDLE after COLS*ROWS cycles; busy = (state == CLEAR).
REQ-020 SHALL ignore clear pulses while in CLEAR (no restart).
REQ-021 SHALL render with 2-cycle latency: pixel coordinates at cycle N produce word_pixel/pixel_valid at N+2, fully pipelined, one pixel per cycle.
REQ-022 SHALL treat a pixel as inside when enable is high and the offset from (TEXT_X0, TEXT_Y0) is non-negative and within the panel extent (8*SCALE*COLS along the line axis, 8*SCALE*ROWS across), using signed 13-bit offset arithmetic.
REQ-023 ORIENT=0: col = dx/(8*SCALE), row = dy/(8*SCALE), glyph byte = (dy/SCALE)%8, bit = 7-(dx/SCALE)%8.
REQ-024 ORIENT=1: col = COLS-1-dy/(8*SCALE), row = dx/(8*SCALE), glyph byte = (dx/SCALE)%8, bit = (dy/SCALE)%8.
REQ-025 SHALL use a 40-entry 64-bit glyph ROM (0-9, a-z with h at 36, '-' 37, heart 38, blank 39), byte 0 at bits [63:56]; codes 40..63 render blank.
REQ-026 SHALL output FG_COLOR with pixel_valid=1 on a set glyph bit inside the panel, else BG_COLOR with pixel_valid=0.
REQ-027 SHALL make a write accepted at cycle N visible to pixels sampled at N+1 or later; read/write same address in one cycle returns old data.

Reset
REQ-028 SHALL on rst_n low asynchronously set word_pixel=BG_COLOR, pixel_valid=0, pipeline valids=0, blink state=0, and state=CLEAR at address 0 (busy=1, wr_ready=0), so the buffer is blanked after reset.
REQ-029 SHALL abort an in-progress clear on reset and restart it from address 0 on release.

Configuration
REQ-030 SHALL, with TEXT_BLINK_EN defined, add input wr_blink (1), store it per character, count frame_start pulses, toggle a blink phase every 32 frames, and render blink-marked characters as background while phase=1; CLEAR resets stored blink bits to 0.
REQ-031 SHALL, without TEXT_BLINK_EN, omit wr_blink, the frame counter and blink storage; frame_start is unused.

Structure
REQ-032 SHALL place glyph ROM contents, code constants (CHAR_BLANK=39, CHAR_HEART=38, CHAR_DASH=37) and the FSM state enum in package text_pkg.
REQ-033 SHALL implement the glyph ROM as sub-module text_glyph_rom (registered 64-bit read, 1-cycle latency).

Verification
REQ-034 Reset release -> busy high exactly COLS*ROWS=36 cycles, then wr_ready=1; all pixels BG_COLOR, pixel_valid=0.
REQ-035 ORIENT=0, SCALE=1, origin (0,0): write code 1 at addr 0; pixel (4,1) -> FG_COLOR, pixel_valid=1 two cycles later; pixel (0,0) -> BG_COLOR.
REQ-036 wr_valid and clear in the same IDLE cycle -> write not accepted, busy next cycle, target reads blank afterwards.
REQ-037 Pixel at (TEXT_X0-1, TEXT_Y0) and one past the panel far edge -> pixel_valid=0; enable=0 over a lit glyph -> pixel_valid=0.
REQ-038 Code 50 written -> its cell renders entirely BG_COLOR.
REQ-039 TEXT_BLINK_EN: blinking heart -> visible frames 0-31, hidden 32-63, visible from 64; non-blink neighbour always visible.
